// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Contents: the arbiter state encoding, the grant encoding, and the default
// address/data widths used by mem_port_arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Fetch-starvation counter for the memory port arbiter.
// Counts consecutive data grants issued while a fetch was waiting and raises
// force_i once the limit is reached, so the next contested grant goes to fetch.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   grant_valid    - a grant is issued this cycle
//   grant_d        - the grant goes to the data side
//   other_pending  - the fetch side was requesting at the grant
//   force_i        - limit reached; fetch wins the next contested grant
module arb_starve_cnt #(
  parameter int unsigned MAX_D_CONSEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_valid,
  input  logic grant_d,
  input  logic other_pending,
  output logic force_i
);

  localparam int unsigned CNT_W = (MAX_D_CONSEC < 1) ? 1 : $clog2(MAX_D_CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_CONSEC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (grant_valid) begin
      if (grant_d && other_pending) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign force_i = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (i_*) and
// load/store (d_*). One transaction at a time; data has priority except when
// fetch has been passed over MAX_D_CONSEC times in a row.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   i_req, i_addr / i_rdata, i_ready  - fetch request and completion
//   d_req, d_we, d_addr, d_wdata /
//   d_rdata, d_ready                  - load/store request and completion
//   mem_req, mem_we, mem_addr,
//   mem_wdata / mem_rdata, mem_ready  - memory side, held until mem_ready
// All outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state;
  grant_t     grant;
  logic       grant_valid;
  logic       force_i;

  always_comb begin
    grant_valid = (state == IDLE) && (i_req || d_req);
    grant       = GNT_I;
    if (d_req && !(i_req && force_i)) begin
      grant = GNT_D;
    end
  end

  arb_starve_cnt #(
    .MAX_D_CONSEC(MAX_D_CONSEC)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .grant_valid  (grant_valid),
    .grant_d      (grant == GNT_D),
    .other_pending(i_req),
    .force_i      (force_i)
  );

  // RESP never arbitrates, so a requester still holding req during its
  // ready pulse cannot be granted twice for one access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_req <= 1'b1;
            if (grant == GNT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= BUSY_D;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
              state    <= BUSY_I;
            end
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
            state   <= RESP;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_ready <= 1'b1;
            state   <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported main memory interface between the instruction-fetch path (I) and the load/store path (D) of the RISC-V core.
- Accepts one outstanding level request per side and grants one transaction at a time.
- Data accesses have priority, with a bounded-starvation rule for fetch.
- Returns read data and a one-cycle ready pulse to the granted requester; the pipeline stalls on `req & ~ready`.

## Interface
- `ADDR_W`, default 30: word address width.
- `DATA_W`, default 32: data width.
- `MAX_D_CONSEC`, default 4: maximum consecutive D grants while `i_req` is pending.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request, held high until `i_ready`.
- `i_addr` in ADDR_W: fetch word address.
- `i_rdata` out DATA_W: fetched instruction.
- `i_ready` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: load/store request, held high until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: load/store word address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data.
- `d_ready` out 1: one-cycle completion pulse for load/store.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid when `mem_ready`=1.
- `mem_ready` in 1: memory completion, any wait count ≥0.

## Operation
States:
- IDLE: arbitration.
- BUSY_I, BUSY_D: transaction in flight.
- RESP: completion pulse.

IDLE arbitration:
- If neither request is high: stay in IDLE.
- If only one request is high: grant it.
- If both are high: grant D, unless `starve_cnt == MAX_D_CONSEC`, in which case grant I.

On a grant, IDLE → BUSY_x:
- `mem_addr`, `mem_we` and `mem_wdata` are registered from the granted side.
- `mem_we`=0 for I.
- `mem_req`=1.

BUSY_x:
- Outputs are held stable.
- Requester inputs are ignored.
- When `mem_ready`=1: go to RESP, `mem_req`←0, `mem_rdata` is captured into `x_rdata` (loads and fetches only; a store leaves `d_rdata` unchanged).

RESP:
- `x_ready`=1 for exactly this cycle.
- Always returns to IDLE. No arbitration happens in RESP, so the served requester's stale `req` cannot cause a regrant.

`starve_cnt` (width clog2(MAX_D_CONSEC+1)) is updated at each IDLE grant:
- D grant with `i_req`=1: increment, saturating at MAX_D_CONSEC.
- I grant: clear to 0.
- D grant with `i_req`=0: clear to 0.

Other behaviour:
- `i_rdata` and `d_rdata` hold their last value between accesses.
- Reset values: state IDLE; all outputs 0; `starve_cnt` 0.
- Reset mid-transaction: the next state is IDLE and `mem_req` goes low. The in-flight memory access is abandoned and no ready pulse is issued; the memory model must tolerate a dropped request.
- A `mem_ready` seen in IDLE or RESP is ignored.

## Timing
- Request high in IDLE at cycle t → `mem_req` high from t+1.
- `mem_ready` sampled high in cycle k → `x_ready` and `x_rdata` valid in cycle k+1.
- Minimum latency, zero-wait memory (`mem_ready` at t+1): ready at t+2.
- Maximum throughput: one transaction per 3 cycles.
- Requester rules: `req` must drop the cycle after its ready pulse, unless a new access is intended; `addr`/`data` may change any time after the grant.
- Simultaneous `i_req`/`d_req` rising in the same IDLE cycle: the arbitration rule above applies.
- No combinational paths from `mem_*` inputs to outputs; all outputs are registered.

## Structure
Shared core package holds:
- the `arb_state_t` enum (IDLE, BUSY_I, BUSY_D, RESP);
- the `grant_t` encoding (GNT_I, GNT_D);
- default ADDR_W/DATA_W constants.

Sub-module `arb_starve_cnt` holds the saturating counter.
- Inputs: `clk`, `rst`, `grant_valid`, `grant_d`, `other_pending`.
- Output: `force_i`.

Remaining FSM, capture registers and muxing live in the top module.

## Test plan
- Lone fetch, `i_addr`=0x10, `mem_ready` at t+1, `mem_rdata`=0x00500093 → `mem_addr`=0x10 and `mem_we`=0 at t+1; `i_ready`=1, `i_rdata`=0x00500093 at t+2.
- Lone store, `d_addr`=0x200, `d_wdata`=0xDEADBEEF, 3 wait cycles → `mem_we`=1 and `mem_wdata`=0xDEADBEEF held 4 cycles; `d_ready` one pulse; `d_rdata` unchanged.
- `i_req` and `d_req` rise together, both held, MAX_D_CONSEC=4, D re-requests immediately after each `d_ready` → grant order D,D,D,D,I,D,…; `starve_cnt` clears on the I grant.
- `rst` asserted in BUSY_D with `mem_req`=1 → next cycle `mem_req`=0, state IDLE, no `d_ready`; a later `mem_ready` pulse is ignored.
- Requester keeps `req` high through its RESP cycle, other side idle → exactly one `mem_req` per intended access; the next grant is no earlier than the IDLE cycle after RESP.
- Random `mem_ready` waits of 0–7 cycles, 1000 mixed I/D accesses, checked against a reference memory model → data match, `mem_*` stable while busy, at most one ready pulse per grant.
